led_pattern_engine: RTL and testbench

- Parametrised LED pattern generator for the board LED bank.
- A prescaler produces a periodic step tick. On each tick the LED register advances one step of the selected pattern.
- Two push buttons are synchronised and debounced. Button 0 cycles through the pattern modes; button 1 toggles pause.
- Sits directly between the board buttons/LED pins and the clock.

---
 rtl/led_pattern_engine.sv | 184 ++++++++++++++++++
 tb/tb_led_pattern_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_engine.sv
// Purpose : LED pattern generator with debounced mode/pause buttons and a step prescaler.
// Latency : raw button edge -> press pulse 2+DEBOUNCE_CYCLES cycles, applied on the following edge.
// Backpr. : none; free-running pin-level block with no flow control.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   buttons  raw asynchronous buttons, [0] = mode, [1] = pause
//   leds     registered LED drive (NUM_LEDS bits)
//   mode     registered current mode (0 BLINK, 1 ROT_L, 2 ROT_R, 3 BOUNCE, 4 COUNT)
//   paused   registered pause state
//   tick     registered one-cycle pattern step pulse
module led_pattern_engine #(
  parameter int NUM_LEDS        = 6,
  parameter int TICK_DIV        = 13_500_000,
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          buttons,
  output logic [NUM_LEDS-1:0] leds,
  output logic [2:0]          mode,
  output logic                paused,
  output logic                tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    MODE_BLINK  = 3'd0,
    MODE_ROT_L  = 3'd1,
    MODE_ROT_R  = 3'd2,
    MODE_BOUNCE = 3'd3,
    MODE_COUNT  = 3'd4
  } mode_e;

  // ---------------------------------------------------------------- buttons
  logic [1:0]    btn_norm;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];

  assign btn_norm = buttons ^ {2{BTN_ACTIVE_LOW}};

  // A level is accepted after it has differed from the debounced level on
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      deb_d[b]   = deb_q[b];
      cnt_d[b]   = '0;
      press_d[b] = 1'b0;
      if (sync2_q[b] != deb_q[b]) begin
        if (cnt_q[b] == DEB_MAX) begin
          deb_d[b]   = sync2_q[b];
          press_d[b] = sync2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q <= btn_norm;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // ---------------------------------------------------------------- pattern
  mode_e               mode_q, mode_d, mode_eff;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic                paused_q, paused_d;
  logic                tick_q, tick_d;
  logic                up_q, up_d;
  logic                wrap;

  function automatic logic [NUM_LEDS-1:0] seed_of(input mode_e m);
    logic [NUM_LEDS-1:0] s;
    case (m)
      MODE_ROT_L, MODE_BOUNCE: s = NUM_LEDS'(1);
      MODE_ROT_R:              s = {1'b1, {(NUM_LEDS-1){1'b0}}};
      default:                 s = '0;
    endcase
    return s;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    case (m)
      MODE_BLINK:  n = MODE_ROT_L;
      MODE_ROT_L:  n = MODE_ROT_R;
      MODE_ROT_R:  n = MODE_BOUNCE;
      MODE_BOUNCE: n = MODE_COUNT;
      default:     n = MODE_BLINK;
    endcase
    return n;
  endfunction

  // Out-of-range mode values behave as BLINK.
  assign mode_eff = (mode_q > MODE_COUNT) ? MODE_BLINK : mode_q;
  assign wrap     = !paused_q && (presc_q == PRESC_MAX);

  always_comb begin
    mode_d   = mode_q;
    leds_d   = leds_q;
    up_d     = up_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    // A pause press coinciding with a tick still lets that tick's step land.
    paused_d = paused_q ^ press_q[1];
    if (press_q[0]) begin
      // Mode change overrides a coincident tick: its step and pulse are dropped.
      mode_d  = next_mode(mode_eff);
      leds_d  = seed_of(next_mode(mode_eff));
      up_d    = 1'b1;
      presc_d = '0;
    end else if (!paused_q) begin
      presc_d = wrap ? '0 : presc_q + PW'(1);
      tick_d  = wrap;
      if (wrap) begin
        mode_d = mode_eff;
        case (mode_eff)
          MODE_ROT_L: leds_d = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
          MODE_ROT_R: leds_d = {leds_q[0], leds_q[NUM_LEDS-1:1]};
          MODE_BOUNCE: begin
            // Flip direction as the end LED is reached so it is shown for one tick.
            if (up_q) begin
              leds_d = leds_q << 1;
              if (leds_d[NUM_LEDS-1]) up_d = 1'b0;
            end else begin
              leds_d = leds_q >> 1;
              if (leds_d[0]) up_d = 1'b1;
            end
          end
          MODE_COUNT: leds_d = leds_q + NUM_LEDS'(1);
          default:    leds_d = ~leds_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_BLINK;
      leds_q   <= '0;
      up_q     <= 1'b1;
      presc_q  <= '0;
      paused_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      leds_q   <= leds_d;
      up_q     <= up_d;
      presc_q  <= presc_d;
      paused_q <= paused_d;
      tick_q   <= tick_d;
    end
  end

  assign leds   = leds_q;
  assign mode   = mode_q;
  assign paused = paused_q;
  assign tick   = tick_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Purpose : self-checking bench for led_pattern_engine against a step-count reference model.
// Latency : model predicts every output every cycle; checks sampled on the falling edge.
// Backpr. : none.
module tb_led_pattern_engine;

  localparam int N   = 6;
  localparam int TD  = 4;
  localparam int DEB = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   buttons;
  logic [N-1:0] leds;
  logic [2:0]   mode;
  logic         paused;
  logic         tick;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_pattern_engine #(
    .NUM_LEDS(N), .TICK_DIV(TD), .DEBOUNCE_CYCLES(DEB), .BTN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons),
    .leds(leds), .mode(mode), .paused(paused), .tick(tick)
  );

  // Reference state: LEDs are derived from (mode, steps since seed).
  int       m_mode, m_steps, m_phase;
  bit       m_paused, m_tick;
  bit [1:0] m_s1, m_s2, m_deb, m_ev;
  int       m_run [2];

  function automatic logic [N-1:0] exp_leds(input int m, input int s);
    int p, k;
    logic [N-1:0] v;
    v = '0;
    case (m)
      0: v = (s % 2 != 0) ? {N{1'b1}} : {N{1'b0}};
      1: v = N'(1) << (s % N);
      2: v = N'(1) << (N - 1 - (s % N));
      3: begin
        p = 2 * (N - 1);
        k = s % p;
        v = N'(1) << ((k < N) ? k : p - k);
      end
      4: v = N'(s % (1 << N));
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_steps = 0; m_phase = 0;
    m_paused = 1'b0; m_tick = 1'b0;
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_ev = '0;
    m_run[0] = 0; m_run[1] = 0;
  endtask

  task automatic model_clock(input logic [1:0] raw);
    bit       wrap;
    bit [1:0] ev_now;
    ev_now = m_ev;
    wrap   = !m_paused && (m_phase == TD - 1);
    m_tick = 1'b0;
    if (ev_now[0]) begin
      m_mode  = (m_mode + 1) % 5;
      m_steps = 0;
      m_phase = 0;
    end else if (!m_paused) begin
      m_phase = (m_phase + 1) % TD;
      m_tick  = wrap;
      if (wrap) m_steps++;
    end
    if (ev_now[1]) m_paused = !m_paused;
    // A new level is accepted once it has persisted DEB synchronised samples.
    for (int b = 0; b < 2; b++) begin
      m_ev[b] = 1'b0;
      if (m_s2[b] != m_deb[b]) begin
        if (m_run[b] + 1 == DEB) begin
          m_deb[b] = m_s2[b];
          m_ev[b]  = m_s2[b];
          m_run[b] = 0;
        end else begin
          m_run[b]++;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic check_outputs();
    check_eq("leds",   32'(leds),   32'(exp_leds(m_mode, m_steps)));
    check_eq("mode",   32'(mode),   32'(m_mode));
    check_eq("paused", 32'(paused), 32'(m_paused));
    check_eq("tick",   32'(tick),   32'(m_tick));
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_clock(buttons);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic press(input int b, input int hold, input int gap);
    buttons[b] = 1'b1;
    run(hold);
    buttons[b] = 1'b0;
    run(gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] frozen;
    int           om;
    bit           found;

    rst_n   = 1'b0;
    buttons = 2'b00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_leds",   32'(leds),   32'd0);
    check_eq("rst_mode",   32'(mode),   32'd0);
    check_eq("rst_paused", 32'(paused), 32'd0);
    check_eq("rst_tick",   32'(tick),   32'd0);
    rst_n = 1'b1;

    // Idle BLINK: ticks on cycles 4, 8, 12.
    for (int c = 1; c <= 13; c++) begin
      step_cycle();
      check_eq("idle_tick", 32'(tick), 32'((c % 4) == 0));
    end
    check_eq("idle_leds", 32'(leds), 32'h3F);

    // Mode button held 10 cycles -> ROT_L, then run through a full rotation.
    press(0, 10, 10);
    check_eq("mode_rotl", 32'(mode), 32'd1);
    run(28);

    // Two more presses -> BOUNCE.
    press(0, 6, 8);
    press(0, 6, 8);
    check_eq("mode_bounce", 32'(mode), 32'd3);
    run(52);

    // COUNT through a full 64-step wrap.
    press(0, 6, 8);
    check_eq("mode_count", 32'(mode), 32'd4);
    run(TD * 64 + 6);

    // Two-cycle glitch on pause is rejected.
    buttons[1] = 1'b1;
    run(2);
    buttons[1] = 1'b0;
    run(10);
    check_eq("glitch_paused", 32'(paused), 32'd0);

    // Held pause press freezes LEDs; a second press resumes.
    press(1, 6, 8);
    check_eq("pause_on", 32'(paused), 32'd1);
    frozen = exp_leds(m_mode, m_steps);
    run(20);
    check_eq("pause_frozen", 32'(leds), 32'(frozen));
    press(1, 6, 8);
    check_eq("pause_off", 32'(paused), 32'd0);
    run(7);

    // Mode event landing on a tick edge: seed loads, step and pulse dropped.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_phase == 2 && !m_paused) found = 1'b1;
      else step_cycle();
    end
    check_eq("align_found", 32'(found), 32'd1);
    buttons[0] = 1'b1;
    run(5);
    om = m_mode;
    step_cycle();
    check_eq("align_tick", 32'(tick), 32'd0);
    check_eq("align_leds", 32'(leds), 32'(exp_leds((om + 1) % 5, 0)));
    buttons[0] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step_cycle();
      check_eq("align_next_tick", 32'(tick), 32'(c == 4));
    end

    // Random button activity, including simultaneous presses.
    for (int k = 0; k < 40; k++) begin
      buttons = 2'($urandom_range(0, 3));
      run(int'($urandom_range(1, 8)));
    end
    buttons = 2'b00;
    run(10);

    // Reach BOUNCE, then reset asynchronously mid-pattern.
    for (int k = 0; k < 5 && m_mode != 3; k++) press(0, 5, 8);
    check_eq("pre_reset_mode", 32'(mode), 32'd3);
    if (m_paused) press(1, 5, 8);
    run(10);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_leds", 32'(leds), 32'd0);
    check_eq("async_rst_mode", 32'(mode), 32'd0);
    check_eq("async_rst_tick", 32'(tick), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step_cycle();
      check_eq("post_rst_tick", 32'(tick), 32'((c % 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
